// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EXE/MEM register, data-memory access
// with wait-state handshake and timeout, load extraction, and the MEM/WB register.
module mem_stage #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [1:0]  emsize,
  input  logic        emsign,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ready,
  output logic        mstall,
  output logic        mwreg,
  output logic        mm2reg,
  output logic [31:0] malu,
  output logic [4:0]  mrn,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn,
  output logic        merr_align,
  output logic        merr_bus
);

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timeout;

  logic             mwmem;
  logic [1:0]       msize;
  logic             msign;
  logic [31:0]      mb;

  logic             memop;
  logic             aligned;
  logic [31:0]      wmo_nxt;

  // Size 11 is reserved and behaves as a word everywhere below.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return ~lo[0];
      default: return (lo == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] b);
    case (size)
      2'b00:   return {4{b[7:0]}};
      2'b01:   return {2{b[15:0]}};
      default: return b;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0]  size,
                                           input logic        sign,
                                           input logic [1:0]  lo,
                                           input logic [31:0] rdata);
    logic signed [7:0]  bv;
    logic signed [15:0] hv;
    bv = rdata[{lo, 3'b000} +: 8];
    hv = lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   return sign ? 32'(bv) : {24'd0, bv};
      2'b01:   return sign ? 32'(hv) : {16'd0, hv};
      default: return rdata;
    endcase
  endfunction

  // EXE/MEM boundary: frozen while an access is outstanding
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
      msize  <= 2'b00;
      msign  <= 1'b0;
      malu   <= 32'd0;
      mb     <= 32'd0;
      mrn    <= 5'd0;
    end else if (!mstall) begin
      mwreg  <= ewreg;
      mm2reg <= em2reg;
      mwmem  <= ewmem;
      msize  <= emsize;
      msign  <= emsign;
      malu   <= ealu;
      mb     <= eb;
      mrn    <= ern;
    end
  end

  assign memop      = mm2reg | mwmem;
  assign aligned    = is_aligned(msize, malu[1:0]);
  assign merr_align = memop & ~aligned;

  assign dm_req   = memop & aligned;
  assign dm_we    = dm_req & mwmem;
  assign dm_addr  = {malu[31:2], 2'b00};
  assign dm_wdata = lane_wdata(msize, mb);
  assign dm_be    = dm_req ? lane_be(msize, malu[1:0]) : 4'b0000;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The cycle that reaches the wait limit without dm_ready is the abort cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req && !dm_ready) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_W'(1);
        end
      end
      BUSY: begin
        if (!dm_req || dm_ready) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == WAIT_LIM) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign mstall   = dm_req & ~dm_ready & ~timeout;
  assign merr_bus = timeout;

  assign wmo_nxt = (dm_req && !timeout) ? load_ext(msize, msign, malu[1:0], dm_rdata) : 32'd0;

  // MEM/WB boundary: a bubble is inserted while M is stalled
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
      wmo    <= 32'd0;
      walu   <= 32'd0;
      wrn    <= 5'd0;
    end else if (!mstall) begin
      wwreg  <= mwreg & ~merr_align;
      wm2reg <= mm2reg;
      wmo    <= wmo_nxt;
      walu   <= malu;
      wrn    <= mrn;
    end else begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage pipelined MIPS core, directly downstream of the EXE stage.
- Holds the EXE/MEM pipeline register and drives the data-memory access (wait-state handshake, byte/half lanes, alignment check, timeout).
- Holds the MEM/WB pipeline register and exports the M-stage fields that the forwarding/hazard unit needs.
- Stalls upstream stages while a memory access is outstanding.

Parameters:
- WAIT_MAX, 15: maximum dm_ready wait cycles before the access is aborted with a bus error.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  asynchronous active-low reset
- ewreg  in  1  EXE instruction writes the register file
- em2reg  in  1  EXE instruction is a load
- ewmem  in  1  EXE instruction is a store
- emsize  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
- emsign  in  1  sign-extend byte/half loads
- ealu  in  32  ALU result / effective address
- eb  in  32  store data
- ern  in  5  destination register
- dm_req  out  1  memory request
- dm_we  out  1  request is a write
- dm_addr  out  32  word-aligned address {malu[31:2],2'b00}
- dm_wdata  out  32  lane-replicated store data
- dm_be  out  4  byte enables, bit i = byte lane i (little-endian)
- dm_rdata  in  32  read data, valid when dm_ready=1
- dm_ready  in  1  access complete this cycle
- mstall  out  1  freeze PC, IF/ID and ID/EXE this cycle
- mwreg, mm2reg  out  1 each  M-stage fields for forwarding
- malu  out  32  M-stage address/result for forwarding
- mrn  out  5  M-stage destination register
- wwreg, wm2reg  out  1 each  WB-stage controls
- wmo  out  32  extended load data
- walu  out  32  WB-stage ALU result
- wrn  out  5  WB-stage destination register
- merr_align  out  1  one-cycle pulse: misaligned access detected
- merr_bus  out  1  one-cycle pulse: access timed out

Behaviour:
- Reset (clrn=0, asynchronous): all M and W register fields, wmo, walu, wrn = 0; FSM in IDLE; wait counter = 0; merr_* = 0.
- M register: on posedge clk, loads all e* fields when mstall=0, holds when mstall=1.
- memop = mm2reg|mwmem.
- Alignment: half requires malu[0]=0; word requires malu[1:0]=00.
- Misaligned memop:
  - no dm_req; store dropped; no stall.
  - merr_align asserted for the cycle the op is in M.
  - W receives wwreg=0 (load write suppressed).
- FSM states IDLE and BUSY; dm_req = aligned memop in either state.
  - IDLE: if dm_ready=1, the access completes in 0 wait cycles with no stall; else go to BUSY with mstall=1 and counter=1.
  - BUSY: dm_req held; dm_addr, dm_we, dm_wdata and dm_be stay stable (M frozen).
    - dm_ready=1: complete, mstall=0, go to IDLE, counter cleared.
    - counter==WAIT_MAX with no ready: abort; merr_bus pulses; load data forced to 0; mstall=0; go to IDLE.
    - Otherwise: counter++.
- Stall: mstall = aligned memop & ~dm_ready & ~timeout-abort (combinational on dm_ready).
- W register, on posedge:
  - mstall=0: W loads the M fields, plus wmo from extracted dm_rdata.
  - mstall=1: bubble (wwreg=0, wm2reg=0; other fields don't-care, hold).
- Store lanes:
  - byte: wdata = {4{eb[7:0]}}, be = 1<<malu[1:0].
  - half: wdata = {2{eb[15:0]}}, be = malu[1] ? 1100 : 0011.
  - word: wdata = eb, be = 1111.
- Load extraction: select byte/half by malu[1:0]; zero- or sign-extend per msign; word passes through.
- Non-memory instructions pass M→W in one cycle; dm_req=0.
- Reset mid-access: FSM returns to IDLE and dm_req drops immediately; the access is lost.

Test Plan:
- ALU op, ealu=0x1234, ern=5, ewreg=1 → next edge mrn=5; following edge wrn=5, walu=0x1234, dm_req never high.
- Word store, ealu=0x100, eb=0xDEADBEEF, dm_ready tied 1 → dm_req=1, dm_we=1, dm_be=1111, dm_addr=0x100, mstall=0.
- Byte load with sign, ealu=0x103, dm_rdata=0x80112233, dm_ready after 3 cycles → mstall high exactly 3 cycles, W bubbles during the stall, then wmo=0xFFFFFF80.
- Half store, ealu=0x202, eb=0x0000ABCD → dm_be=1100, dm_wdata=0xABCDABCD; half load at 0x201 → merr_align pulse, no dm_req, wwreg=0.
- dm_ready held 0 → mstall for WAIT_MAX=15 cycles, merr_bus pulse, load wmo=0, pipeline resumes.
- clrn driven low during BUSY → dm_req, mstall, wwreg and mrn all 0 asynchronously; after release, FSM is in IDLE.
